// File: rtl/comm_pkg.sv
// Shared definitions for the 2-bit symbol link, used by both the receive
// decoder and the transmit framer.
package comm_pkg;

  localparam int SYM_W  = 2;
  localparam int WORD_W = 4;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_D0   = 2'b01,
    ST_D1   = 2'b10,
    ST_STOP = 2'b11
  } rx_state_e;

endpackage

// File: rtl/deco_2to4.sv
// Combinational 2-to-4 one-hot decoder; inverse of the transmit-side encoder.
module deco_2to4
  import comm_pkg::*;
(
  input  logic [SYM_W-1:0]  sym_i,
  output logic [WORD_W-1:0] word_o
);

  // One-hot expansion of the received symbol
  always_comb begin
    word_o = 4'b0000;
    case (sym_i)
      2'b00:   word_o = 4'b0001;
      2'b01:   word_o = 4'b0010;
      2'b10:   word_o = 4'b0100;
      2'b11:   word_o = 4'b1000;
      default: word_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/deco_rx_2to4.sv
// Receive-side framer: deserialises start/A/B/stop frames on bit_en strobes,
// decodes the symbol to one-hot and holds it in a one-entry valid/ready buffer.
module deco_rx_2to4
  import comm_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              ser_in,
  input  logic              out_ready,
  input  logic              ovr_clr,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  rx_state_e         state_q, state_d;
  logic              bit_a_q, bit_a_d;
  logic              bit_b_q, bit_b_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;

  logic              stop_good_s;
  logic              stop_bad_s;
  logic              drain_s;
  logic [SYM_W-1:0]  sym_s;
  logic [WORD_W-1:0] word_s;

  // Frame sequencer; only advances on strobe cycles
  always_comb begin
    state_d     = state_q;
    bit_a_d     = bit_a_q;
    bit_b_d     = bit_b_q;
    stop_good_s = 1'b0;
    stop_bad_s  = 1'b0;
    if (bit_en) begin
      case (state_q)
        ST_IDLE: begin
          if (ser_in == START_BIT) begin
            state_d = ST_D0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_D0: begin
          bit_a_d = ser_in;
          state_d = ST_D1;
        end
        ST_D1: begin
          bit_b_d = ser_in;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (ser_in == STOP_BIT) begin
            stop_good_s = 1'b1;
          end else begin
            stop_bad_s = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Bit order selection: A is the first data bit after start
  always_comb begin
    if (MSB_FIRST) begin
      sym_s = {bit_a_q, bit_b_q};
    end else begin
      sym_s = {bit_b_q, bit_a_q};
    end
  end

  deco_2to4 u_deco (
    .sym_i  (sym_s),
    .word_o (word_s)
  );

  // Output buffer: a slot freed by a same-cycle handshake may be refilled
  always_comb begin
    drain_s     = out_valid_q & out_ready;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (stop_good_s && (!out_valid_q || drain_s)) begin
      out_data_d  = word_s;
      out_valid_d = 1'b1;
    end else if (drain_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // Set has priority over clear
    if (stop_good_s && out_valid_q && !out_ready) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    frame_err_d = stop_bad_s;
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_a_q     <= 1'b0;
      bit_b_q     <= 1'b0;
      out_data_q  <= 4'b0000;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_a_q     <= bit_a_d;
      bit_b_q     <= bit_b_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule
